// File: rtl/mmcm_drp_writer_if.sv
// rtl/mmcm_drp_writer_if.sv - request, DRP, MMCM and status signals of mmcm_drp_writer
interface mmcm_drp_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_addr;
  logic [15:0] in_data;
  logic [15:0] in_mask;
  logic        in_last;
  logic        drp_den;
  logic        drp_dwe;
  logic [6:0]  drp_daddr;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        mmcm_rst;
  logic        mmcm_locked;
  logic        busy;
  logic        done;
  logic        error;

  // Writer block side
  modport slave (
    input  in_valid, in_addr, in_data, in_mask, in_last, drp_do, drp_drdy, mmcm_locked,
    output in_ready, drp_den, drp_dwe, drp_daddr, drp_di, mmcm_rst, busy, done, error
  );

  // Requester, DRP port and MMCM side
  modport master (
    output in_valid, in_addr, in_data, in_mask, in_last, drp_do, drp_drdy, mmcm_locked,
    input  in_ready, drp_den, drp_dwe, drp_daddr, drp_di, mmcm_rst, busy, done, error
  );
endinterface

// File: rtl/mmcm_drp_writer.sv
// rtl/mmcm_drp_writer.sv - masked read-modify-write DRP sequencer holding the MMCM in reset; DRP_TIMEOUT_EN adds a watchdog
module mmcm_drp_writer #(
  parameter int unsigned LOCK_TIMEOUT = 32'd20000000,
  parameter int unsigned DRDY_TIMEOUT = 32'd255
) (
  input logic              clock,
  input logic              reset,
  mmcm_drp_writer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, NEXT, LOCK_WAIT
  } state_e;

  state_e      state_q, state_d;
  logic [6:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [15:0] mask_q, mask_d;
  logic        last_q, last_d;
  logic [15:0] wr_q, wr_d;
  logic        mmcm_rst_q, mmcm_rst_d;
  logic [2:0]  settle_q, settle_d;   // LOCK_WAIT cycles elapsed, saturating at 4

  logic accept;
  logic advance;
  logic timeout;
  logic abort;

  assign accept = bus.in_valid && ((state_q == IDLE) || (state_q == NEXT));

  // Event that lets the current wait state move on
  always_comb begin
    case (state_q)
      RD_WAIT, WR_WAIT: advance = bus.drp_drdy;
      LOCK_WAIT:        advance = (settle_q == 3'd4) && bus.mmcm_locked;
      default:          advance = 1'b0;
    endcase
  end

`ifdef DRP_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;

  // Limit check for the wait state currently occupied
  always_comb begin
    case (state_q)
      RD_WAIT, WR_WAIT: timeout = (cnt_q == DRDY_TIMEOUT);
      LOCK_WAIT:        timeout = (cnt_q == LOCK_TIMEOUT);
      default:          timeout = 1'b0;
    endcase
  end

  // Count cycles spent in a wait state, restarting on every state entry
  always_comb begin
    cnt_d = 32'd0;
    if ((state_d == state_q) &&
        ((state_q == RD_WAIT) || (state_q == WR_WAIT) || (state_q == LOCK_WAIT))) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Watchdog counter register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= 32'd0;
    else       cnt_q <= cnt_d;
  end
`else
  logic unused_limits;
  assign unused_limits = ^{LOCK_TIMEOUT, DRDY_TIMEOUT};
  assign timeout = 1'b0;
`endif

  // A wait that expires without its event abandons the sequence
  assign abort = timeout && !advance;

  // State register and captured request / write value
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= 7'd0;
      data_q     <= 16'd0;
      mask_q     <= 16'd0;
      last_q     <= 1'b0;
      wr_q       <= 16'd0;
      mmcm_rst_q <= 1'b0;
      settle_q   <= 3'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      last_q     <= last_d;
      wr_q       <= wr_d;
      mmcm_rst_q <= mmcm_rst_d;
      settle_q   <= settle_d;
    end
  end

  // Next state, request capture, merged write value and MMCM reset control
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    data_d     = data_q;
    mask_d     = mask_q;
    last_d     = last_q;
    wr_d       = wr_q;
    mmcm_rst_d = mmcm_rst_q;
    settle_d   = (settle_q == 3'd4) ? settle_q : settle_q + 3'd1;
    if (accept) begin
      addr_d = bus.in_addr;
      data_d = bus.in_data;
      mask_d = bus.in_mask;
      last_d = bus.in_last;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d    = RD_REQ;
          mmcm_rst_d = 1'b1;
        end
      end
      RD_REQ: state_d = RD_WAIT;
      RD_WAIT: begin
        if (advance) begin
          wr_d    = (bus.drp_do & mask_q) | (data_q & ~mask_q);
          state_d = WR_REQ;
        end
      end
      WR_REQ: state_d = WR_WAIT;
      WR_WAIT: begin
        if (advance) begin
          if (last_q) begin
            state_d    = LOCK_WAIT;
            mmcm_rst_d = 1'b0;
            settle_d   = 3'd0;
          end else begin
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        if (accept) state_d = RD_REQ;
      end
      LOCK_WAIT: begin
        if (advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d    = IDLE;
      mmcm_rst_d = 1'b0;
    end
  end

  // Outputs decoded from state; DRP lines stay zero unless strobed
  always_comb begin
    bus.in_ready  = (state_q == IDLE) || (state_q == NEXT);
    bus.drp_den   = (state_q == RD_REQ) || (state_q == WR_REQ);
    bus.drp_dwe   = (state_q == WR_REQ);
    bus.drp_daddr = ((state_q == RD_REQ) || (state_q == WR_REQ)) ? addr_q : 7'd0;
    bus.drp_di    = (state_q == WR_REQ) ? wr_q : 16'd0;
    bus.mmcm_rst  = mmcm_rst_q;
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == LOCK_WAIT) && advance;
    bus.error     = abort;
  end

endmodule

// File: tb/tb_mmcm_drp_writer.sv
// tb/tb_mmcm_drp_writer.sv - self-checking bench for mmcm_drp_writer (DRP_TIMEOUT_EN enables the watchdog test)
module tb_mmcm_drp_writer;
  localparam int DRDY_TO = 12;
  localparam int LOCK_TO = 200;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  mmcm_drp_writer_if bus ();

  mmcm_drp_writer #(.LOCK_TIMEOUT(LOCK_TO), .DRDY_TIMEOUT(DRDY_TO)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [15:0] data;
  } xact_t;

  typedef struct {
    logic [6:0]  a;
    logic [15:0] d;
    logic [15:0] m;
    int          gap;
  } req_t;

  typedef struct {
    logic [6:0]  a;
    logic [15:0] d;
    logic [15:0] m;
    logic [15:0] rd;
    logic [15:0] di;
  } vec_t;

  int total = 0;
  int bad   = 0;

  logic [15:0] mem [128];
  logic [15:0] model_mem [128];
  xact_t obs_q [$];
  req_t  seq_q [$];

  int   cyc = 0;
  int   drdy_delay = 1;
  int   drdy_cnt = 0;
  logic drdy_enable = 1'b1;
  logic drdy_force = 1'b0;
  int   lock_delay = 2;
  int   lock_cnt = 0;
  logic outstanding = 1'b0;
  logic pend_we;
  logic [6:0]  pend_addr;
  logic [15:0] pend_di;
  logic req_open = 1'b0;
  logic prev_rst = 1'b0;
  logic acc_seen;
  int acc_cyc, wr_cyc, wdrdy_cyc, fall_cyc, done_cyc, err_cyc;
  int done_cnt, err_cnt, rst_rise, rst_fall, viol, idle_nz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    done_cnt = 0; err_cnt = 0; rst_rise = 0; rst_fall = 0; viol = 0; idle_nz = 0;
  endtask

  // One clock: observe at negedge, then drive DRP slave and MMCM lock after the edge
  task automatic cycle();
    @(negedge clock);
    acc_seen = bus.in_valid && bus.in_ready;
    if (bus.in_ready && req_open) viol++;
    if (bus.in_ready && bus.busy && !bus.mmcm_rst) viol++;
    if (acc_seen) begin
      acc_cyc  = cyc;
      req_open = 1'b1;
    end
    if (bus.drp_den) begin
      if (outstanding) viol++;
      obs_q.push_back('{we: bus.drp_dwe, addr: bus.drp_daddr, data: bus.drp_di});
      if (bus.drp_dwe) wr_cyc = cyc;
      outstanding = 1'b1;
      pend_we = bus.drp_dwe; pend_addr = bus.drp_daddr; pend_di = bus.drp_di;
      drdy_cnt = drdy_delay;
    end else if (bus.drp_dwe || bus.drp_daddr != 7'd0 || bus.drp_di != 16'd0) begin
      idle_nz++;
    end
    if (bus.done) begin done_cnt++; done_cyc = cyc; end
    if (bus.error) begin err_cnt++; err_cyc = cyc; end
    if (bus.mmcm_rst && !prev_rst) rst_rise++;
    if (!bus.mmcm_rst && prev_rst) begin rst_fall++; fall_cyc = cyc; end
    prev_rst = bus.mmcm_rst;
    @(posedge clock);
    #1;
    cyc++;
    bus.drp_drdy = drdy_force;
    bus.drp_do   = 16'h0;
    if (drdy_cnt > 0) begin
      drdy_cnt--;
      if (drdy_cnt == 0 && drdy_enable) begin
        bus.drp_drdy = 1'b1;
        if (pend_we) begin
          mem[pend_addr] = pend_di;
          wdrdy_cyc = cyc;
          req_open = 1'b0;
        end else begin
          bus.drp_do = mem[pend_addr];
        end
        outstanding = 1'b0;
      end
    end
    if (bus.mmcm_rst) begin
      bus.mmcm_locked = 1'b0;
      lock_cnt = 0;
    end else if (!bus.mmcm_locked) begin
      lock_cnt++;
      if (lock_cnt >= lock_delay) bus.mmcm_locked = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.drp_drdy = 1'b0;
    drdy_cnt = 0; outstanding = 1'b0; req_open = 1'b0;
    drdy_force = 1'b0; drdy_enable = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    prev_rst = 1'b0;
  endtask

  task automatic send(input req_t r, input logic last);
    repeat (r.gap) cycle();
    bus.in_valid = 1'b1;
    bus.in_addr  = r.a;
    bus.in_data  = r.d;
    bus.in_mask  = r.m;
    bus.in_last  = last;
    for (int n = 0; n < 500; n++) begin
      cycle();
      if (acc_seen) break;
    end
    chk("accept_wait", 32'(acc_seen), 32'd1);
    bus.in_valid = 1'b0;
    bus.in_addr  = 7'($urandom);
    bus.in_data  = 16'($urandom);
    bus.in_mask  = 16'($urandom);
    bus.in_last  = 1'($urandom);
  endtask

  task automatic wait_end(input int bound);
    int d0 = done_cnt;
    int e0 = err_cnt;
    for (int n = 0; n < bound; n++) begin
      if (done_cnt != d0 || err_cnt != e0) break;
      cycle();
    end
    chk("end_wait", 32'(done_cnt != d0 || err_cnt != e0), 32'd1);
  endtask

  // Drive seq_q as one reconfiguration and compare against the register-file model
  task automatic run_seq(input string tag);
    xact_t exp_q [$];
    logic [15:0] nv;
    int n;
    int exp_done;
    n = seq_q.size();
    foreach (seq_q[i]) begin
      exp_q.push_back('{we: 1'b0, addr: seq_q[i].a, data: 16'h0});
      nv = (model_mem[seq_q[i].a] & seq_q[i].m) | (seq_q[i].d & ~seq_q[i].m);
      model_mem[seq_q[i].a] = nv;
      exp_q.push_back('{we: 1'b1, addr: seq_q[i].a, data: nv});
    end
    clear_obs();
    foreach (seq_q[i]) send(seq_q[i], 1'(i == n - 1));
    wait_end(3000);
    repeat (6) cycle();
    chk($sformatf("%s_xact_count", tag), obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("%s_xact%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
    chk($sformatf("%s_rst_rise", tag), rst_rise, 1);
    chk($sformatf("%s_rst_fall", tag), rst_fall, 1);
    chk($sformatf("%s_done_cnt", tag), done_cnt, 1);
    chk($sformatf("%s_err_cnt", tag), err_cnt, 0);
    chk($sformatf("%s_protocol", tag), viol, 0);
    chk($sformatf("%s_idle_zero", tag), idle_nz, 0);
    chk($sformatf("%s_rst_release", tag), fall_cyc, wdrdy_cyc + 1);
    exp_done = fall_cyc + ((lock_delay - 1 > 4) ? lock_delay - 1 : 4);
    chk($sformatf("%s_done_time", tag), done_cyc, exp_done);
  endtask

  initial begin
    vec_t vecs [5];
    req_t r;
    int n;
    int mem_bad;

    vecs[0] = '{a: 7'h08, d: 16'h1041, m: 16'hF000, rd: 16'hA5A5, di: 16'hA041};
    vecs[1] = '{a: 7'h7F, d: 16'hFFFF, m: 16'hFFFF, rd: 16'h1234, di: 16'h1234};
    vecs[2] = '{a: 7'h00, d: 16'hBEEF, m: 16'h0000, rd: 16'h1234, di: 16'hBEEF};
    vecs[3] = '{a: 7'h15, d: 16'h00FF, m: 16'hFF00, rd: 16'h5A5A, di: 16'h5AFF};
    vecs[4] = '{a: 7'h42, d: 16'hAAAA, m: 16'h0F0F, rd: 16'h5555, di: 16'hA5A5};

    bus.in_valid = 1'b0; bus.in_addr = 7'd0; bus.in_data = 16'd0; bus.in_mask = 16'd0;
    bus.in_last = 1'b0; bus.drp_do = 16'd0; bus.drp_drdy = 1'b0; bus.mmcm_locked = 1'b0;
    for (int i = 0; i < 128; i++) begin
      mem[i] = 16'($urandom);
      model_mem[i] = mem[i];
    end

    #2 reset = 1'b1;
    #1;
    chk("reset_outputs", 32'({bus.in_ready, bus.drp_den, bus.drp_dwe, bus.drp_daddr, bus.drp_di,
                              bus.mmcm_rst, bus.busy, bus.done, bus.error}), 32'({1'b1, 29'd0}));
    do_reset();

    // Table-driven single requests
    for (int v = 0; v < 5; v++) begin
      mem[vecs[v].a] = vecs[v].rd;
      model_mem[vecs[v].a] = vecs[v].rd;
      drdy_delay = 1;
      lock_delay = 2;
      seq_q.delete();
      r = '{a: vecs[v].a, d: vecs[v].d, m: vecs[v].m, gap: 1};
      seq_q.push_back(r);
      run_seq($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_di", v), (obs_q.size() > 1) ? 32'(obs_q[1].data) : 32'hDEAD0000, 32'(vecs[v].di));
      chk($sformatf("vec%0d_latency", v), wr_cyc - acc_cyc, 3);
    end

    // Three back-to-back requests, last on the third
    seq_q.delete();
    for (int k = 0; k < 3; k++) begin
      r = '{a: 7'(8'h20 + 8'(k)), d: 16'($urandom), m: 16'($urandom), gap: k};
      seq_q.push_back(r);
    end
    drdy_delay = 2;
    lock_delay = 7;
    run_seq("three");

    // Randomized reconfiguration sequences
    for (int s = 0; s < 8; s++) begin
      seq_q.delete();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        r = '{a: 7'($urandom_range(0, 7)), d: 16'($urandom), m: 16'($urandom), gap: $urandom_range(0, 3)};
        seq_q.push_back(r);
      end
      drdy_delay = $urandom_range(1, 4);
      lock_delay = $urandom_range(1, 10);
      run_seq($sformatf("rnd%0d", s));
    end

    // drdy high in IDLE and RD_REQ must be ignored
    clear_obs();
    mem[7'h30] = 16'h3C3C;
    model_mem[7'h30] = 16'h0F3C;
    drdy_delay = 3;
    lock_delay = 2;
    drdy_force = 1'b1;
    repeat (3) cycle();
    bus.in_valid = 1'b1; bus.in_addr = 7'h30; bus.in_data = 16'h0F0F; bus.in_mask = 16'h00FF; bus.in_last = 1'b1;
    cycle();
    chk("spur_accept", 32'(acc_seen), 32'd1);
    bus.in_valid = 1'b0;
    drdy_force = 1'b0;
    wait_end(200);
    repeat (4) cycle();
    chk("spur_xacts", obs_q.size(), 2);
    chk("spur_read", (obs_q.size() > 0) ? 32'(obs_q[0]) : 32'hDEAD0000, 32'({1'b0, 7'h30, 16'h0000}));
    chk("spur_write", (obs_q.size() > 1) ? 32'(obs_q[1]) : 32'hDEAD0000, 32'({1'b1, 7'h30, 16'h0F3C}));
    chk("spur_latency", wr_cyc - acc_cyc, 5);
    chk("spur_done", done_cnt, 1);

    // Reset while waiting for the write drdy
    clear_obs();
    drdy_delay = 6;
    r = '{a: 7'h11, d: 16'h7777, m: 16'h00F0, gap: 0};
    send(r, 1'b1);
    for (int k = 0; k < 100; k++) begin
      if (obs_q.size() >= 2) break;
      cycle();
    end
    chk("wrwait_reached", obs_q.size(), 2);
    cycle();
    reset = 1'b1;
    #1;
    chk("midrst_outputs", 32'({bus.in_ready, bus.drp_den, bus.drp_dwe, bus.drp_daddr, bus.drp_di,
                               bus.mmcm_rst, bus.busy, bus.done, bus.error}), 32'({1'b1, 29'd0}));
    do_reset();
    drdy_delay = 1;
    lock_delay = 3;
    seq_q.delete();
    seq_q.push_back(r);
    run_seq("after_rst");

`ifdef DRP_TIMEOUT_EN
    // drdy never returned: watchdog must fire and drop back to IDLE
    clear_obs();
    drdy_enable = 1'b0;
    r = '{a: 7'h22, d: 16'h1111, m: 16'h0000, gap: 0};
    send(r, 1'b1);
    wait_end(200);
    chk("to_err_cnt", err_cnt, 1);
    chk("to_err_time", err_cyc - (acc_cyc + 2), DRDY_TO);
    chk("to_idle", 32'({bus.busy, bus.mmcm_rst, bus.in_ready}), 32'd1);
    chk("to_no_done", done_cnt, 0);
    do_reset();
`endif

    mem_bad = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== model_mem[i]) mem_bad++;
    chk("mem_image", mem_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
